// File: rtl/tecla_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, confirmation-timer debounce on
// both edges, one-cycle press/release pulses and optional auto-repeat.
module tecla_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic pressed
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW      = $clog2(REP_MAX) + 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] db_cnt, db_cnt_nx;
    logic [RW-1:0] rep_cnt, rep_cnt_nx;
    logic          press_nx, release_nx, pressed_nx;
    logic          sync1, sync2;
    logic          key_s;

    assign key_s = ~sync2;

    // Synchroniser flops reset to the released level so key_s starts at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            state         <= IDLE;
            db_cnt        <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            pressed       <= 1'b0;
        end else begin
            sync1         <= key_n;
            sync2         <= sync1;
            state         <= state_nx;
            db_cnt        <= db_cnt_nx;
            rep_cnt       <= rep_cnt_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            pressed       <= pressed_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        db_cnt_nx  = db_cnt;
        rep_cnt_nx = rep_cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        pressed_nx = pressed;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_nx  = PRESS_WAIT;
                    db_cnt_nx = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_nx  = IDLE;
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx   = HELD;
                    press_nx   = 1'b1;
                    pressed_nx = 1'b1;
                    rep_cnt_nx = '0;
                    db_cnt_nx  = '0;
                end else begin
                    db_cnt_nx = db_cnt + DW'(1);
                end
            end
            HELD, REPEAT: begin
                // Repeat counter only runs when repeats exist, so it can never wrap.
                if (!key_s) begin
                    state_nx  = RELEASE_WAIT;
                    db_cnt_nx = '0;
                end else if (REPEAT_EN) begin
                    if (rep_cnt == ((state == HELD) ? DLY_LAST : PER_LAST)) begin
                        state_nx   = REPEAT;
                        press_nx   = 1'b1;
                        rep_cnt_nx = '0;
                    end else begin
                        rep_cnt_nx = rep_cnt + RW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed restarts the full repeat delay.
                if (key_s) begin
                    state_nx   = HELD;
                    rep_cnt_nx = '0;
                    db_cnt_nx  = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                    pressed_nx = 1'b0;
                    db_cnt_nx  = '0;
                end else begin
                    db_cnt_nx = db_cnt + DW'(1);
                end
            end
            default: begin
                state_nx   = IDLE;
                db_cnt_nx  = '0;
                rep_cnt_nx = '0;
                pressed_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tecla_debounce.sv
// Scoreboard bench: run-length reference model feeds per-DUT event queues,
// a negedge monitor pops and compares whenever a DUT pulses.
module tb_tecla_debounce;

    localparam int D      = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    typedef struct {
        int cyc;
        bit rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic [1:0] pp, rp, pr;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  run_mon = 1'b0;
    ev_t q0[$];
    ev_t q1[$];

    // Model state: index 0 tracks the repeat-enabled DUT, index 1 the single-pulse one.
    bit  m_s1 = 1'b1, m_s2 = 1'b1;
    bit  m_prs[2];
    int  m_run[2];
    int  m_next[2];

    always #5 clk = ~clk;

    tecla_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk(clk), .rst(rst), .key_n(key_n),
        .press_pulse(pp[0]), .release_pulse(rp[0]), .pressed(pr[0])
    );

    tecla_debounce #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_EN(1'b0)
    ) dut_one (
        .clk(clk), .rst(rst), .key_n(key_n),
        .press_pulse(pp[1]), .release_pulse(rp[1]), .pressed(pr[1])
    );

    task automatic push_ev(input int i, input int c, input bit rel);
        ev_t e;
        e.cyc = c;
        e.rel = rel;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference: a press needs D+1 consecutive synchronised "down" samples,
    // a release D+1 "up" samples; repeats are scheduled by absolute cycle.
    initial begin
        bit ks;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_s1 = 1'b1;
                m_s2 = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    m_prs[i] = 1'b0;
                    m_run[i] = 0;
                end
            end else begin
                ks   = ~m_s2;
                m_s2 = m_s1;
                m_s1 = key_n;
                for (int i = 0; i < 2; i++) begin
                    if (!m_prs[i]) begin
                        m_run[i] = ks ? m_run[i] + 1 : 0;
                        if (m_run[i] == D + 1) begin
                            m_prs[i]  = 1'b1;
                            m_run[i]  = 0;
                            m_next[i] = cyc + DELAY;
                            push_ev(i, cyc, 1'b0);
                        end
                    end else if (!ks) begin
                        m_run[i]++;
                        if (m_run[i] == D + 1) begin
                            m_prs[i] = 1'b0;
                            m_run[i] = 0;
                            push_ev(i, cyc, 1'b1);
                        end
                    end else if (m_run[i] != 0) begin
                        m_run[i]  = 0;
                        m_next[i] = cyc + DELAY;
                    end else if (i == 0 && cyc == m_next[i]) begin
                        m_next[i] = cyc + PERIOD;
                        push_ev(i, cyc, 1'b0);
                    end
                end
            end
        end
    end

    // Monitor
    initial begin
        ev_t e;
        bit  have;
        forever begin
            @(negedge clk);
            if (run_mon) begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (pr[i] !== m_prs[i]) begin
                        errors++;
                        $display("FAIL pressed[%0d] cyc=%0d got=%0b exp=%0b", i, cyc, pr[i], m_prs[i]);
                    end
                    if (pp[i] || rp[i]) begin
                        checks++;
                        have = 1'b0;
                        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        if (pp[i] && rp[i]) begin
                            errors++;
                            $display("FAIL both_pulses[%0d] cyc=%0d got=1,1 exp=not both", i, cyc);
                        end else if (!have) begin
                            errors++;
                            $display("FAIL unexpected_pulse[%0d] cyc=%0d got rel=%0b exp=none", i, cyc, rp[i]);
                        end else if (e.cyc != cyc || e.rel != rp[i]) begin
                            errors++;
                            $display("FAIL pulse[%0d] got cyc=%0d rel=%0b exp cyc=%0d rel=%0b",
                                     i, cyc, rp[i], e.cyc, e.rel);
                        end
                    end
                    while (i == 0 && q0.size() > 0 && q0[0].cyc < cyc) begin
                        e = q0.pop_front();
                        checks++; errors++;
                        $display("FAIL missed_pulse[0] got=none exp cyc=%0d rel=%0b", e.cyc, e.rel);
                    end
                    while (i == 1 && q1.size() > 0 && q1[0].cyc < cyc) begin
                        e = q1.pop_front();
                        checks++; errors++;
                        $display("FAIL missed_pulse[1] got=none exp cyc=%0d rel=%0b", e.cyc, e.rel);
                    end
                end
            end
        end
    end

    task automatic hold(input logic k, input int n);
        key_n = k;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int len;
        @(posedge clk); #2;
        run_mon = 1'b1;

        // Reset with key held, then press must follow after release of reset.
        key_n = 1'b0;
        hold(1'b0, 2);
        checks++;
        if ({pp, rp, pr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000", {pp, rp, pr});
        end
        rst = 1'b1;
        hold(1'b0, 20);
        hold(1'b1, 20);

        // Clean press with long hold (repeats on one DUT, single pulse on the other).
        hold(1'b0, 100);
        hold(1'b1, 20);

        // Bounce on press.
        hold(1'b0, 3); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 1);
        hold(1'b0, 30);

        // Release glitch during hold, then full release.
        hold(1'b1, 2);
        hold(1'b0, 25);
        hold(1'b1, 20);

        // Reset mid-debounce with key still held.
        hold(1'b0, 5);
        rst = 1'b0;
        hold(1'b0, 2);
        rst = 1'b1;
        hold(1'b0, 20);
        hold(1'b1, 20);

        // Random segments: short bounces, long holds, occasional reset.
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
                rst = 1'b1;
            end else begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
                hold(1'($urandom_range(0, 1)), len);
            end
        end

        hold(1'b1, 20);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d,%0d pending exp=0,0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
